// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative unsigned multiply (shift-add)
// and divide (restoring), one bit per cycle, with registered result/hi/zero and a done pulse.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] ra_q, ra_d;   // mult: running high word / div: partial remainder
  logic [WIDTH-1:0] rb_q, rb_d;   // mult: multiplier shifting into low word / div: dividend->quotient
  logic [WIDTH-1:0] rc_q, rc_d;   // mult: multiplicand / div: divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_c;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Single-cycle operations, evaluated directly on the input operands.
  always_comb begin
    alu_c = '0;
    case (ALUop)
      OP_AND:  alu_c = opA & opB;
      OP_OR:   alu_c = opA | opB;
      OP_ADD:  alu_c = opA + opB;
      OP_SUB:  alu_c = opA - opB;
      OP_SLT:  alu_c = WIDTH'($signed(opA) < $signed(opB));
      OP_SLTU: alu_c = WIDTH'(opA < opB);
      OP_NOR:  alu_c = ~(opA | opB);
      default: alu_c = '0;
    endcase
  end

  // One iteration of the shift-add multiplier or restoring divider.
  always_comb begin
    mul_sum  = {1'b0, ra_q} + (rb_q[0] ? {1'b0, rc_q} : {(WIDTH+1){1'b0}});
    div_sh   = {ra_q, rb_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, rc_q});
    div_diff = div_sh - {1'b0, rc_q};
    if (op_q == OP_DIVU) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {rb_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], rb_q[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d  = ALUop;
          cnt_d = '0;
          if (ALUop == OP_MULTU) begin
            ra_d    = '0;
            rb_d    = opB;
            rc_d    = opA;
            busy_d  = 1'b1;
            state_d = BUSY;
          end else if (ALUop == OP_DIVU && opB != '0) begin
            ra_d    = '0;
            rb_d    = opA;
            rc_d    = opB;
            busy_d  = 1'b1;
            state_d = BUSY;
          end else if (ALUop == OP_DIVU) begin
            result_d = '1;
            hi_d     = opA;
            zero_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            result_d = alu_c;
            hi_d     = '0;
            zero_d   = (alu_c == '0);
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        ra_d  = step_hi;
        rb_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = step_lo;
          hi_d     = step_hi;
          zero_d   = (step_lo == '0);
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=32 and WIDTH=8 instances checked every cycle against an
// arithmetic reference model, plus directed cases with hand-computed expectations.
module tb_alu_seq;

  logic clk;
  logic        rst_i [2];
  logic        st    [2];
  logic [3:0]  op    [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];

  logic [31:0] dres  [2];
  logic [31:0] dhi   [2];
  logic        dzero [2];
  logic        dbusy [2];
  logic        ddone [2];

  logic [31:0] res32, hi32;
  logic [7:0]  res8, hi8;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst_i[0]), .start(st[0]), .ALUop(op[0]),
    .opA(a[0]), .opB(b[0]), .result(res32), .hi(hi32),
    .zero(dzero[0]), .busy(dbusy[0]), .done(ddone[0])
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_i[1]), .start(st[1]), .ALUop(op[1]),
    .opA(a[1][7:0]), .opB(b[1][7:0]), .result(res8), .hi(hi8),
    .zero(dzero[1]), .busy(dbusy[1]), .done(ddone[1])
  );

  assign dres[0] = res32;
  assign dhi[0]  = hi32;
  assign dres[1] = {24'd0, res8};
  assign dhi[1]  = {24'd0, hi8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wd_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic longint unsigned mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference arithmetic for one operation at width w.
  task automatic calc(input int w, input logic [3:0] o, input longint unsigned x,
                      input longint unsigned y, output longint unsigned r,
                      output longint unsigned h, output bit multi);
    longint unsigned m = mask_of(w);
    longint sx, sy;
    sx = (((x >> (w - 1)) & 64'd1) != 0) ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    sy = (((y >> (w - 1)) & 64'd1) != 0) ? longint'(y) - longint'(64'd1 << w) : longint'(y);
    h = 0;
    multi = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = (x + y) & m;
      4'b0110: r = (x - y) & m;
      4'b0111: r = (sx < sy) ? 1 : 0;
      4'b1000: r = (x < y) ? 1 : 0;
      4'b1100: r = ~(x | y) & m;
      4'b1101: begin
        r = (x * y) & m;
        h = ((x * y) >> w) & m;
        multi = 1'b1;
      end
      4'b1110: begin
        if (y == 0) begin
          r = m;
          h = x;
        end else begin
          r = x / y;
          h = x % y;
          multi = 1'b1;
        end
      end
      default: r = 0;
    endcase
  endtask

  longint unsigned m_res [2], m_hi [2], p_res [2], p_hi [2];
  bit m_zero [2], m_busy [2], m_done [2], mvalid [2];
  int m_rem [2];

  task automatic model_step(input int i);
    int w = wd_of(i);
    longint unsigned m = mask_of(w);
    longint unsigned r, h;
    bit multi;
    if (rst_i[i]) begin
      m_res[i] = 0; m_hi[i] = 0; m_zero[i] = 1; m_busy[i] = 0; m_done[i] = 0;
      m_rem[i] = 0; mvalid[i] = 1;
    end else if (!mvalid[i]) begin
      m_done[i] = 0;
    end else if (m_rem[i] > 0) begin
      m_rem[i]  = m_rem[i] - 1;
      m_done[i] = 0;
      m_busy[i] = (m_rem[i] > 0);
      if (m_rem[i] == 0) begin
        m_res[i] = p_res[i]; m_hi[i] = p_hi[i]; m_zero[i] = (p_res[i] == 0); m_done[i] = 1;
      end
    end else begin
      m_done[i] = 0;
      m_busy[i] = 0;
      if (st[i]) begin
        calc(w, op[i], longint'(a[i]) & m, longint'(b[i]) & m, r, h, multi);
        if (multi) begin
          p_res[i] = r; p_hi[i] = h; m_rem[i] = w; m_busy[i] = 1;
        end else begin
          m_res[i] = r; m_hi[i] = h; m_zero[i] = (r == 0); m_done[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s w%0d got %0h expected %0h at %0t", name, wd_of(i), got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        cmp("result", i, 64'(dres[i]), 64'(m_res[i]));
        cmp("hi", i, 64'(dhi[i]), 64'(m_hi[i]));
        cmp("zero", i, 64'(dzero[i]), 64'(m_zero[i]));
        cmp("busy", i, 64'(dbusy[i]), 64'(m_busy[i]));
        cmp("done", i, 64'(ddone[i]), 64'(m_done[i]));
      end
    end
  end

  // Launch one op and count cycles until done (bounded).
  task automatic issue(input int i, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int lat);
    @(negedge clk);
    st[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y;
    @(negedge clk);
    st[i] = 1'b0;
    lat = 1;
    while (!ddone[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed(input int i);
    int w = wd_of(i);
    logic [31:0] m = 32'(mask_of(w));
    int lat, n, saw;
    issue(i, 4'b0010, 32'd5, 32'd7, lat);
    cmp("add_lat", i, 64'(lat), 64'd1);
    cmp("add_res", i, 64'(dres[i]), 64'd12);
    cmp("add_zero", i, 64'(dzero[i]), 64'd0);
    issue(i, 4'b0110, 32'd3, 32'd3, lat);
    cmp("sub_res", i, 64'(dres[i]), 64'd0);
    cmp("sub_zero", i, 64'(dzero[i]), 64'd1);
    issue(i, 4'b0111, m, 32'd1, lat);
    cmp("slt_res", i, 64'(dres[i]), 64'd1);
    issue(i, 4'b1000, m, 32'd1, lat);
    cmp("sltu_res", i, 64'(dres[i]), 64'd0);
    issue(i, 4'b1100, 32'd0, 32'd0, lat);
    cmp("nor_res", i, 64'(dres[i]), 64'(m));
    issue(i, 4'b1101, m, 32'd2, lat);
    cmp("mul_lat", i, 64'(lat), 64'(w + 1));
    cmp("mul_hi", i, 64'(dhi[i]), 64'd1);
    cmp("mul_res", i, 64'(dres[i]), 64'(m - 32'd1));
    issue(i, 4'b1110, 32'd100, 32'd7, lat);
    cmp("div_lat", i, 64'(lat), 64'(w + 1));
    cmp("div_res", i, 64'(dres[i]), 64'd14);
    cmp("div_hi", i, 64'(dhi[i]), 64'd2);
    issue(i, 4'b1110, 32'd9, 32'd0, lat);
    cmp("div0_lat", i, 64'(lat), 64'd1);
    cmp("div0_res", i, 64'(dres[i]), 64'(m));
    cmp("div0_hi", i, 64'(dhi[i]), 64'd9);
    issue(i, 4'b0011, 32'd5, 32'd5, lat);
    cmp("undef_res", i, 64'(dres[i]), 64'd0);
    // ADD requested mid-multiply must be ignored; operand changes too.
    @(negedge clk); st[i] = 1; op[i] = 4'b1101; a[i] = 32'd6; b[i] = 32'd7;
    @(negedge clk); st[i] = 0;
    @(negedge clk); st[i] = 1; op[i] = 4'b0010; a[i] = 32'd1; b[i] = 32'd1;
    @(negedge clk); st[i] = 0; op[i] = 4'b0110; a[i] = 32'd99; b[i] = 32'd99;
    n = 3;
    while (!ddone[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmp("busyign_lat", i, 64'(n), 64'(w + 1));
    cmp("busyign_res", i, 64'(dres[i]), 64'd42);
    cmp("busyign_hi", i, 64'(dhi[i]), 64'd0);
    // Reset partway through a multiply.
    @(negedge clk); st[i] = 1; op[i] = 4'b1101; a[i] = m; b[i] = 32'd3;
    @(negedge clk); st[i] = 0;
    repeat (((w == 32) ? 10 : 5) - 1) @(negedge clk);
    rst_i[i] = 1;
    @(negedge clk); rst_i[i] = 0;
    cmp("rst_res", i, 64'(dres[i]), 64'd0);
    cmp("rst_zero", i, 64'(dzero[i]), 64'd1);
    cmp("rst_busy", i, 64'(dbusy[i]), 64'd0);
    saw = 0;
    repeat (w + 4) begin
      @(negedge clk);
      if (ddone[i]) saw++;
    end
    cmp("rst_nodone", i, 64'(saw), 64'd0);
    // Back-to-back ADDs with start held high.
    @(negedge clk); st[i] = 1; op[i] = 4'b0010; a[i] = 32'd1; b[i] = 32'd2;
    @(negedge clk);
    cmp("b2b_done1", i, 64'(ddone[i]), 64'd1);
    cmp("b2b_res1", i, 64'(dres[i]), 64'd3);
    a[i] = 32'd10; b[i] = 32'd20;
    @(negedge clk); st[i] = 0;
    cmp("b2b_done2", i, 64'(ddone[i]), 64'd1);
    cmp("b2b_res2", i, 64'(dres[i]), 64'd30);
    @(negedge clk);
    cmp("b2b_done3", i, 64'(ddone[i]), 64'd0);
  endtask

  logic [3:0] oplist [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1000, 4'b1100, 4'b1101, 4'b1110};

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1; st[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0;
      mvalid[i] = 0; m_rem[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_i[0] = 0; rst_i[1] = 0;
    for (int i = 0; i < 2; i++) begin
      cmp("reset_res", i, 64'(dres[i]), 64'd0);
      cmp("reset_hi", i, 64'(dhi[i]), 64'd0);
      cmp("reset_zero", i, 64'(dzero[i]), 64'd1);
      cmp("reset_busy", i, 64'(dbusy[i]), 64'd0);
      cmp("reset_done", i, 64'(ddone[i]), 64'd0);
    end
    directed(0);
    directed(1);
    // Randomized traffic on both instances, checked by the per-cycle model.
    repeat (2000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rst_i[i] = ($urandom_range(0, 99) == 0);
        st[i]    = $urandom_range(0, 1) == 1;
        op[i]    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : oplist[$urandom_range(0, 8)];
        a[i]     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b[i]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 0; st[i] = 0;
    end
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
